// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request and response channels between datapath and data memory
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word data memory answering one load/store at a time after WAIT_CYCLES wait states
module data_mem_responder #(
  parameter int DEPTH       = 16384,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [7:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH];

  logic          ex_write;
  logic [31:0]   ex_addr;
  logic [31:0]   ex_wdata;
  logic          ex_fault;
  logic          ex_now;
  logic [AW-1:0] ex_idx;
  logic [31:0]   ex_rdata;

  // With zero wait states the access executes on the acceptance edge, so it
  // must use the live request fields rather than the not-yet-captured copy.
  always_comb begin
    ex_write = cap_write;
    ex_addr  = cap_addr;
    ex_wdata = cap_wdata;
    if (state == IDLE) begin
      ex_write = bus.req_write;
      ex_addr  = bus.req_addr;
      ex_wdata = bus.req_wdata;
    end
    ex_fault = (ex_addr[1:0] != 2'b00) || ({2'b00, ex_addr[31:2]} >= DEPTH_W);
    ex_idx   = ex_addr[AW+1:2];
    ex_now   = rst && (((state == IDLE) && bus.req_valid && ZERO_WAIT) ||
                       ((state == WAIT) && (cnt == 8'd0)));
    ex_rdata = (ex_fault || ex_write) ? 32'd0 : mem[ex_idx];
  end

  // Memory contents survive reset; gating with rst above keeps an aborted store out.
  always_ff @(posedge clk) begin
    if (ex_now && ex_write && !ex_fault) begin
      mem[ex_idx] <= ex_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      cap_write      <= 1'b0;
      cap_addr       <= 32'd0;
      cap_wdata      <= 32'd0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cap_write     <= bus.req_write;
            cap_addr      <= bus.req_addr;
            cap_wdata     <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (ZERO_WAIT) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= ex_rdata;
              bus.resp_err   <= ex_fault;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= ex_rdata;
            bus.resp_err   <= ex_fault;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench for data_mem_responder with a transaction-level memory model
module tb_data_mem_responder;

  localparam int DEPTH = 16384;
  localparam int WC0   = 2;
  localparam int WC1   = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if b2();
  data_mem_responder_if b0();

  logic        rv [2];
  logic        rw [2];
  logic        rr [2];
  logic [31:0] ra [2];
  logic [31:0] rd [2];
  logic        o_rdy   [2];
  logic        o_valid [2];
  logic        o_err   [2];
  logic [31:0] o_rdata [2];

  assign b2.req_valid  = rv[0];
  assign b2.req_write  = rw[0];
  assign b2.req_addr   = ra[0];
  assign b2.req_wdata  = rd[0];
  assign b2.resp_ready = rr[0];
  assign b0.req_valid  = rv[1];
  assign b0.req_write  = rw[1];
  assign b0.req_addr   = ra[1];
  assign b0.req_wdata  = rd[1];
  assign b0.resp_ready = rr[1];
  assign o_rdy[0]   = b2.req_ready;
  assign o_valid[0] = b2.resp_valid;
  assign o_rdata[0] = b2.resp_rdata;
  assign o_err[0]   = b2.resp_err;
  assign o_rdy[1]   = b0.req_ready;
  assign o_valid[1] = b0.resp_valid;
  assign o_rdata[1] = b0.resp_rdata;
  assign o_err[1]   = b0.resp_err;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC0)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC1)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int wc(input int k);
    return (k == 0) ? WC0 : WC1;
  endfunction

  // Model: one pending transaction per instance; its response appears
  // WAIT_CYCLES+1 cycles after acceptance and the memory effect happens then.
  logic [31:0] mm [int];
  bit          pend  [2];
  int          due   [2];
  bit          done  [2];
  bit          m_w   [2];
  logic [31:0] m_a   [2];
  logic [31:0] m_d   [2];
  logic [31:0] e_rdata [2];
  bit          e_err   [2];
  bit          e_known [2];
  bit          rst_ev = 1'b0;
  int          rst_fall_cyc = -1;

  always @(negedge rst) begin
    rst_ev       = 1'b1;
    rst_fall_cyc = cyc;
  end

  task automatic model_exec(input int k);
    int key;
    key = k * DEPTH + int'(m_a[k] >> 2);
    if ((m_a[k] & 32'd3) != 0 || (m_a[k] >> 2) >= 32'(DEPTH)) begin
      e_err[k] = 1'b1; e_rdata[k] = 32'd0; e_known[k] = 1'b1;
    end else if (m_w[k]) begin
      mm[key] = m_d[k];
      e_err[k] = 1'b0; e_rdata[k] = 32'd0; e_known[k] = 1'b1;
    end else begin
      e_err[k] = 1'b0;
      e_known[k] = mm.exists(key);
      e_rdata[k] = e_known[k] ? mm[key] : 32'd0;
    end
    done[k] = 1'b1;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_ev) begin
        if (pend[k] && !done[k] && rst_fall_cyc >= due[k]) model_exec(k);
        pend[k] = 1'b0;
      end
      if (!rst) begin
        pend[k] = 1'b0;
        chk("rst_req_ready", 32'(o_rdy[k]), 32'd1);
        chk("rst_resp_valid", 32'(o_valid[k]), 32'd0);
        chk("rst_rdata", o_rdata[k], 32'd0);
        chk("rst_err", 32'(o_err[k]), 32'd0);
      end else begin
        if (pend[k] && !done[k] && cyc >= due[k]) model_exec(k);
        chk("req_ready", 32'(o_rdy[k]), 32'(!pend[k]));
        chk("resp_valid", 32'(o_valid[k]), 32'(pend[k] && cyc >= due[k]));
        chk("ready_valid_excl", 32'(o_rdy[k] & o_valid[k]), 32'd0);
        if (pend[k] && cyc >= due[k]) begin
          chk("resp_err", 32'(o_err[k]), 32'(e_err[k]));
          if (e_known[k]) chk("resp_rdata", o_rdata[k], e_rdata[k]);
          if (rr[k]) pend[k] = 1'b0;
        end else if (!pend[k] && rv[k]) begin
          pend[k] = 1'b1;
          done[k] = 1'b0;
          due[k]  = cyc + wc(k) + 1;
          m_w[k]  = rw[k];
          m_a[k]  = ra[k];
          m_d[k]  = rd[k];
        end
      end
    end
    rst_ev = 1'b0;
  end

  task automatic xact(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int bp, output logic [31:0] rdata, output logic err, output int lat);
    int t0;
    int guard;
    rdata = 32'd0; err = 1'b0; lat = -1;
    @(posedge clk); #1;
    rv[k] = 1'b1; rw[k] = w; ra[k] = a; rd[k] = d; rr[k] = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!o_rdy[k] && guard < 100);
    if (!o_rdy[k]) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: req_ready stayed 0 expected 1");
      rv[k] = 1'b0;
      return;
    end
    t0 = cyc;
    @(posedge clk); #1;
    rv[k] = 1'b0; ra[k] = $urandom; rd[k] = $urandom; rw[k] = 1'($urandom_range(0, 1));
    guard = 0;
    do begin @(negedge clk); guard++; end while (!o_valid[k] && guard < 300);
    if (!o_valid[k]) begin
      n_tests++; n_fail++;
      $display("FAIL resp_timeout: resp_valid stayed 0 expected 1");
      return;
    end
    lat = cyc - t0; rdata = o_rdata[k]; err = o_err[k];
    repeat (bp) begin
      @(negedge clk);
      chk("bp_rdata", o_rdata[k], rdata);
      chk("bp_err", 32'(o_err[k]), 32'(err));
      chk("bp_req_ready", 32'(o_rdy[k]), 32'd0);
    end
    @(posedge clk); #1; rr[k] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; rr[k] = 1'b0;
    @(negedge clk);
    chk("ready_after_hs", 32'(o_rdy[k]), 32'd1);
  endtask

  task automatic stream(input int k, input logic [31:0] a);
    int prev;
    prev = -1;
    @(posedge clk); #1;
    rv[k] = 1'b1; rw[k] = 1'b0; ra[k] = a; rr[k] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (o_rdy[k]) begin
        if (prev >= 0) chk("throughput", 32'(cyc - prev), 32'(wc(k) + 2));
        prev = cyc;
      end
    end
    @(posedge clk); #1; rv[k] = 1'b0;
    repeat (wc(k) + 4) @(posedge clk);
    #1; rr[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat;
    int          guard;
    logic [31:0] a;
    int          k;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; rr[i] = 1'b0; ra[i] = 32'd0; rd[i] = 32'd0;
      pend[i] = 1'b0; done[i] = 1'b0; due[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    xact(0, 1'b1, 32'h3E8, 32'h0000_00A5, 0, r, e, lat);
    chk("st_latency", 32'(lat), 32'd3);
    chk("st_rdata", r, 32'd0);
    chk("st_err", 32'(e), 32'd0);
    xact(0, 1'b0, 32'h3E8, 32'd0, 0, r, e, lat);
    chk("ld_latency", 32'(lat), 32'd3);
    chk("ld_rdata", r, 32'h0000_00A5);
    chk("ld_err", 32'(e), 32'd0);

    xact(0, 1'b0, 32'h3E8, 32'd0, 5, r, e, lat);
    chk("bp_ld_rdata", r, 32'h0000_00A5);

    xact(0, 1'b1, 32'h80, 32'h1234_5678, 0, r, e, lat);
    xact(0, 1'b0, 32'h80, 32'd0, 0, r, e, lat);
    chk("captured_inputs", r, 32'h1234_5678);

    xact(0, 1'b1, 32'((DEPTH - 1) * 4), 32'h5A5A_0001, 0, r, e, lat);
    xact(0, 1'b0, 32'h3EA, 32'd0, 0, r, e, lat);
    chk("misalign_err", 32'(e), 32'd1);
    chk("misalign_rdata", r, 32'd0);
    xact(0, 1'b1, 32'(DEPTH * 4), 32'hFFFF_FFFF, 2, r, e, lat);
    chk("oob_err", 32'(e), 32'd1);
    chk("oob_rdata", r, 32'd0);
    xact(0, 1'b0, 32'((DEPTH - 1) * 4), 32'd0, 0, r, e, lat);
    chk("last_word", r, 32'h5A5A_0001);
    chk("last_word_err", 32'(e), 32'd0);

    xact(0, 1'b1, 32'h40, 32'h1122_3344, 0, r, e, lat);
    @(posedge clk); #1;
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h40; rd[0] = 32'hCAFE_F00D; rr[0] = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!o_rdy[0] && guard < 100);
    @(posedge clk); #1 rv[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("async_rst_ready", 32'(o_rdy[0]), 32'd1);
    chk("async_rst_valid", 32'(o_valid[0]), 32'd0);
    chk("async_rst_rdata", o_rdata[0], 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    xact(0, 1'b0, 32'h40, 32'd0, 0, r, e, lat);
    chk("aborted_store", r, 32'h1122_3344);

    xact(1, 1'b1, 32'h0, 32'hDEAD_BEEF, 0, r, e, lat);
    chk("zw_st_latency", 32'(lat), 32'd1);
    xact(1, 1'b0, 32'h0, 32'd0, 0, r, e, lat);
    chk("zw_ld_latency", 32'(lat), 32'd1);
    chk("zw_ld_rdata", r, 32'hDEAD_BEEF);

    stream(1, 32'h0);
    stream(0, 32'h3E8);

    for (int i = 0; i < 60; i++) begin
      k = i % 2;
      case ($urandom_range(0, 9))
        0:       a = 32'((DEPTH - 1) * 4);
        1:       a = ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
        2:       a = 32'(DEPTH * 4) + ($urandom_range(0, 100) << 2);
        default: a = $urandom_range(0, 15) << 2;
      endcase
      xact(k, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), r, e, lat);
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data memory that answers load/store requests from the processor datapath through a valid/ready request channel and a valid/ready response channel. Each access takes a programmable number of wait states, so the multi-cycle and pipelined datapaths can be exercised against realistic memory latency and stalls. It is the responder end of the datapath's data-memory interface: the datapath issues address, write data and read/write intent, and this block accepts, performs and acknowledges them.

## Interface
- DEPTH, 16384: number of 32-bit words; legal word indices 0..DEPTH-1.
- WAIT_CYCLES, 2: wait states per access, range 0..255.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; word index = req_addr[31:2].
- req_wdata  in  32  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  access faulted.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid=1, capture req_write, req_addr, req_wdata; go to WAIT with counter=WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES=0.
- WAIT: req_ready=0; counter decrements each cycle; at counter=0 go to RESP.
- On the WAIT->RESP (or IDLE->RESP) edge the access executes: load captures mem[index] into resp_rdata; store writes captured data into mem[index] and sets resp_rdata=0.
- Fault: req_addr[1:0]!=0 or index>=DEPTH. Faulted access does not touch memory; resp_rdata=0, resp_err=1.
- RESP: resp_valid=1, resp_rdata/resp_err held stable until resp_ready=1; on resp_valid&resp_ready go to IDLE.
- Only one transaction in flight; requests while not in IDLE are not accepted (requester holds them).
- Memory array is not cleared by reset; initial contents are X unless loaded by the bench.
- Inputs are sampled only at the acceptance edge; changes to req_* after acceptance have no effect.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, counter=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. Reset during WAIT or RESP aborts the transaction; a store not yet executed is never written; a store already executed stays written.
- Latency: request accepted at edge of cycle 0 -> resp_valid first high in cycle WAIT_CYCLES+1.
- Throughput: with resp_ready tied 1, one transaction every WAIT_CYCLES+2 cycles; req_ready rises the cycle after the response handshake.
- Load after store to the same word returns the stored value.
- resp_ready held 0: block stays in RESP indefinitely, outputs frozen, req_ready=0.
- req_ready and resp_valid are never high in the same cycle.

## Test plan
- Reset: drive rst=0 mid-WAIT of a store to addr 0x40 -> outputs return to reset values immediately; later load of 0x40 returns its pre-store value.
- Basic store/load, WAIT_CYCLES=2: store 0x0000_00A5 to 0x3E8, then load 0x3E8 -> store response in cycle 3 with rdata=0, err=0; load response 3 cycles after acceptance with rdata=0x0000_00A5.
- Zero wait: WAIT_CYCLES=0, load 0x0 after storing 0xDEAD_BEEF -> resp_valid in cycle 1, rdata=0xDEAD_BEEF; back-to-back requests accepted every 2 cycles.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid rises -> rdata/err stable, req_ready=0 throughout; handshake on release, req_ready=1 next cycle.
- Faults: load 0x3EA (misaligned) and store to byte address DEPTH*4 -> err=1, rdata=0; subsequent load of word DEPTH-1 unaffected.
- Input change after acceptance: alter req_addr/req_wdata during WAIT -> access uses captured values only.
